// File: rtl/pwm_duty_ramp.sv
// Slew-rate limiter feeding pwm_core.duty: walks duty toward a software target in clamped steps.
// Optional sticky irq/irq_clr pair is built only when PWM_RAMP_IRQ_EN is defined.
module pwm_duty_ramp #(
  parameter int RESOLUTION = 10
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  enable,
  input  logic                  target_valid,
  input  logic [RESOLUTION:0]   target_duty,
  input  logic [RESOLUTION:0]   step,
  input  logic [31:0]           rate_dvsr,
  output logic [RESOLUTION:0]   duty,
  output logic                  busy,
  output logic                  done
`ifdef PWM_RAMP_IRQ_EN
  ,
  output logic                  irq,
  input  logic                  irq_clr
`endif
);

  localparam int W = RESOLUTION + 1;
  localparam logic [W-1:0] FULL = {1'b1, {RESOLUTION{1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [W-1:0] duty_q, duty_d;
  logic [W-1:0] tgt_q, tgt_d;
  logic [31:0]  cnt_q, cnt_d;
  logic         done_q, done_d;

  logic [W-1:0] tgtSat;
  logic [W-1:0] stepEff;
  logic [W:0]   upSum;
  logic [W:0]   downLim;

  // One extra bit on the step arithmetic keeps duty+step and tgt+step from wrapping.
  assign tgtSat  = (target_duty > FULL) ? FULL : target_duty;
  assign stepEff = (step == '0) ? W'(1) : step;
  assign upSum   = {1'b0, duty_q} + {1'b0, stepEff};
  assign downLim = {1'b0, tgt_q} + {1'b0, stepEff};

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= IDLE;
      duty_q  <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // A load always wins over a step landing on the same edge.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    if (target_valid) begin
      tgt_d = tgtSat;
      cnt_d = '0;
      if (tgtSat > duty_q) begin
        state_d = UP;
      end else if (tgtSat < duty_q) begin
        state_d = DOWN;
      end else begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end else if ((state_q != IDLE) && enable) begin
      if (cnt_q == rate_dvsr) begin
        cnt_d = '0;
        if (state_q == UP) begin
          if (upSum >= {1'b0, tgt_q}) begin
            duty_d  = tgt_q;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            duty_d = upSum[W-1:0];
          end
        end else begin
          if ({1'b0, duty_q} <= downLim) begin
            duty_d  = tgt_q;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            duty_d = duty_q - stepEff;
          end
        end
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end
  end

  assign duty = duty_q;
  assign busy = (state_q != IDLE);
  assign done = done_q;

`ifdef PWM_RAMP_IRQ_EN
  logic irq_q;

  // Set shares the done_d term so a coincident clear never masks a completion.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= done_d | (irq_q & ~irq_clr);
    end
  end

  assign irq = irq_q;
`endif

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Scoreboard bench for pwm_duty_ramp: an arithmetic ramp model queues expected duty/done
// events per load; a negedge monitor pops one entry whenever duty changes or done pulses.
module tb_pwm_duty_ramp;

  localparam int RES  = 10;
  localparam int FULL = 1 << RES;

  typedef struct {
    int cyc;
    int duty;
    int busy;
    int done;
  } ev_t;

  logic            clk = 1'b0;
  logic            arst_n;
  logic            enable;
  logic            target_valid;
  logic [RES:0]    target_duty;
  logic [RES:0]    step;
  logic [31:0]     rate_dvsr;
  logic [RES:0]    duty;
  logic            busy;
  logic            done;
`ifdef PWM_RAMP_IRQ_EN
  logic            irq;
  logic            irq_clr;
`endif

  ev_t sbQ[$];
  int  cyc = 0;
  int  modelDuty = 0;
  int  nChecks = 0;
  int  nFails = 0;

  pwm_duty_ramp #(.RESOLUTION(RES)) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .enable       (enable),
    .target_valid (target_valid),
    .target_duty  (target_duty),
    .step         (step),
    .rate_dvsr    (rate_dvsr),
    .duty         (duty),
    .busy         (busy),
    .done         (done)
`ifdef PWM_RAMP_IRQ_EN
    ,
    .irq          (irq),
    .irq_clr      (irq_clr)
`endif
  );

  always #5 clk = ~clk;

  // Posedge index; at a negedge, cyc names the edge whose results are visible.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic bit frozen(input int e, input int l, input int fs, input int fl);
    return (fl > 0) && (e >= l + fs) && (e < l + fs + fl);
  endfunction

  // Loads tgt at edge L, holds the inputs for edges L+1..L+hold-1 (enable dropped during the
  // freeze window) and queues every duty change expected in that span from plain arithmetic.
  task automatic applyStimulus(input int tgt, input int stp, input int rate, input int hold,
                               input int fs, input int fl);
    int t, s, d, l, c;
    ev_t ev;
    t = (tgt > FULL) ? FULL : tgt;
    s = (stp == 0) ? 1 : stp;
    d = modelDuty;
    @(negedge clk);
    l = cyc + 1;
    target_valid = 1'b1;
    target_duty  = (RES+1)'(tgt);
    step         = (RES+1)'(stp);
    rate_dvsr    = 32'(rate);
    enable       = !frozen(l, l, fs, fl);
    if (t == d) begin
      ev = '{cyc: l, duty: d, busy: 0, done: 1};
      sbQ.push_back(ev);
    end else begin
      c = 0;
      for (int e = l + 1; e < l + hold; e++) begin
        if (!frozen(e, l, fs, fl)) begin
          c++;
          if (c == rate + 1) begin
            c = 0;
            if (t > d) d = (d + s >= t) ? t : d + s;
            else       d = (d <= t + s) ? t : d - s;
            ev = '{cyc: e, duty: d, busy: (d != t), done: (d == t)};
            sbQ.push_back(ev);
            if (d == t) break;
          end
        end
      end
    end
    modelDuty = d;
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      target_valid = 1'b0;
      enable       = !frozen(l + i, l, fs, fl);
    end
  endtask

  // Monitor: any duty change or done pulse consumes one scoreboard entry.
  initial begin
    int prevDuty;
    ev_t ev;
    prevDuty = 0;
    forever begin
      @(negedge clk);
      if (!arst_n) begin
        prevDuty = duty;
      end else if ((int'(duty) != prevDuty) || (done !== 1'b0)) begin
        if (sbQ.size() == 0) begin
          nChecks++;
          nFails++;
          $display("[TB] FAIL unexpected event: duty %0d done %0b, expected no output change (cycle %0d)",
                   duty, done, cyc);
        end else begin
          ev = sbQ.pop_front();
          checkOutput("event cycle", cyc, ev.cyc);
          checkOutput("duty", int'(duty), ev.duty);
          checkOutput("busy", int'(busy), ev.busy);
          checkOutput("done", int'(done), ev.done);
        end
        prevDuty = duty;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    arst_n       = 1'b0;
    enable       = 1'b0;
    target_valid = 1'b0;
    target_duty  = '0;
    step         = '0;
    rate_dvsr    = '0;
`ifdef PWM_RAMP_IRQ_EN
    irq_clr      = 1'b0;
`endif
    #1;
    checkOutput("reset duty", int'(duty), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset done", int'(done), 0);
    repeat (3) @(negedge clk);
    #1 arst_n = 1'b1;

    $display("[TB] directed ramps");
    applyStimulus(1000, 100, 3, 60, 0, 0);
    applyStimulus(50, 300, 0, 8, 0, 0);
    applyStimulus(2047, 0, 0, 1000, 0, 0);
    applyStimulus(0, 1024, 0, 4, 0, 0);
    applyStimulus(800, 100, 1, 10, 0, 0);
    applyStimulus(200, 100, 1, 20, 0, 0);
    applyStimulus(600, 50, 2, 60, 5, 20);
    applyStimulus(600, 10, 0, 5, 0, 0);
    applyStimulus(300, 60, 1, 40, 1, 10);

    $display("[TB] random ramps");
    for (int i = 0; i < 15; i++) begin
      int tg, sp, rt, hd, fs, fl;
      tg = $urandom_range(0, 2047);
      sp = $urandom_range(0, 400);
      rt = $urandom_range(0, 4);
      hd = $urandom_range(2, 40);
      fs = $urandom_range(1, 10);
      fl = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 8) : 0;
      applyStimulus(tg, sp, rt, hd, fs, fl);
    end

    $display("[TB] async reset mid-ramp");
    applyStimulus(0, 2047, 0, 3, 0, 0);
    applyStimulus(1000, 100, 0, 4, 0, 0);
    @(negedge clk);
    checkOutput("pre-reset duty", int'(duty), 300);
    #1 arst_n = 1'b0;
    #1;
    checkOutput("async reset duty", int'(duty), 0);
    checkOutput("async reset busy", int'(busy), 0);
    checkOutput("async reset done", int'(done), 0);
    modelDuty = 0;
    repeat (2) @(negedge clk);
    #1 arst_n = 1'b1;
    applyStimulus(30, 10, 0, 6, 0, 0);

    repeat (5) @(negedge clk);
    checkOutput("scoreboard drained", sbQ.size(), 0);
    checkOutput("final busy", int'(busy), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
